// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch/jump flush and a stall-cycle counter.
// Latency: one cycle from *_in to *_out; Stall/PCWrite/IFIDWrite are combinational in the same cycle.
// Backpressure: a load-use hazard deasserts PCWrite/IFIDWrite for one cycle and loads a bubble into EX.
module id_ex_stage (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RegWrite_in,
    input  logic        ALUSrc_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        MemToReg_in,
    input  logic        Branch_in,
    input  logic        Jump_in,
    input  logic        LoadType_in,
    input  logic        StoreType_in,
    input  logic [3:0]  ALUOp_in,
    input  logic [2:0]  RegDst_in,
    input  logic [31:0] ReadData1_in,
    input  logic [31:0] ReadData2_in,
    input  logic [31:0] SignExt_in,
    input  logic [31:0] PCPlus4_in,
    input  logic [4:0]  Rs_in,
    input  logic [4:0]  Rt_in,
    input  logic [4:0]  Rd_in,
    input  logic [4:0]  Shamt_in,
    input  logic        Flush,
    output logic        RegWrite_out,
    output logic        ALUSrc_out,
    output logic        MemWrite_out,
    output logic        MemRead_out,
    output logic        MemToReg_out,
    output logic        Branch_out,
    output logic        Jump_out,
    output logic        LoadType_out,
    output logic        StoreType_out,
    output logic [3:0]  ALUOp_out,
    output logic [2:0]  RegDst_out,
    output logic [31:0] ReadData1_out,
    output logic [31:0] ReadData2_out,
    output logic [31:0] SignExt_out,
    output logic [31:0] PCPlus4_out,
    output logic [4:0]  Rs_out,
    output logic [4:0]  Rt_out,
    output logic [4:0]  Rd_out,
    output logic [4:0]  Shamt_out,
    output logic        Valid_out,
    output logic        Stall,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic [15:0] StallCount
);

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       load_type;
        logic       store_type;
        logic [3:0] alu_op;
        logic [2:0] reg_dst;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
    } data_t;

    ctrl_t       ctrl_d;
    ctrl_t       ctrl_q;
    data_t       data_d;
    data_t       data_q;
    logic        valid_q;
    logic        hazard;
    logic        bubble;
    logic [15:0] stall_cnt;

    // Gather the decode-stage inputs into control and data words.
    always_comb begin
        ctrl_d = '{
            reg_write:  RegWrite_in,
            alu_src:    ALUSrc_in,
            mem_write:  MemWrite_in,
            mem_read:   MemRead_in,
            mem_to_reg: MemToReg_in,
            branch:     Branch_in,
            jump:       Jump_in,
            load_type:  LoadType_in,
            store_type: StoreType_in,
            alu_op:     ALUOp_in,
            reg_dst:    RegDst_in
        };
        data_d = '{
            rd1:   ReadData1_in,
            rd2:   ReadData2_in,
            sext:  SignExt_in,
            pc4:   PCPlus4_in,
            rs:    Rs_in,
            rt:    Rt_in,
            rd:    Rd_in,
            shamt: Shamt_in
        };
    end

    // Load in EX whose destination is read by ID; a flush wins so the redirect can proceed.
    // Rt of the ID instruction is compared even if it is not a source (harmless over-stall).
    always_comb begin
        hazard = ctrl_q.mem_read & valid_q & (data_q.rt != 5'd0) &
                 ((data_q.rt == Rs_in) | (data_q.rt == Rt_in)) & ~Flush;
        bubble = Flush | hazard;
    end

    assign Stall     = hazard;
    assign PCWrite   = ~hazard;
    assign IFIDWrite = ~hazard;

    // Control word and valid bit: zeroed on a bubble, otherwise captured.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else if (bubble) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= 1'b1;
        end
    end

    // Data fields are captured every cycle, bubble or not, to keep waveforms readable.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    // Saturating stall-cycle counter; flush cycles never raise hazard so are not counted.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign RegWrite_out  = ctrl_q.reg_write;
    assign ALUSrc_out    = ctrl_q.alu_src;
    assign MemWrite_out  = ctrl_q.mem_write;
    assign MemRead_out   = ctrl_q.mem_read;
    assign MemToReg_out  = ctrl_q.mem_to_reg;
    assign Branch_out    = ctrl_q.branch;
    assign Jump_out      = ctrl_q.jump;
    assign LoadType_out  = ctrl_q.load_type;
    assign StoreType_out = ctrl_q.store_type;
    assign ALUOp_out     = ctrl_q.alu_op;
    assign RegDst_out    = ctrl_q.reg_dst;
    assign ReadData1_out = data_q.rd1;
    assign ReadData2_out = data_q.rd2;
    assign SignExt_out   = data_q.sext;
    assign PCPlus4_out   = data_q.pc4;
    assign Rs_out        = data_q.rs;
    assign Rt_out        = data_q.rt;
    assign Rd_out        = data_q.rd;
    assign Shamt_out     = data_q.shamt;
    assign Valid_out     = valid_q;
    assign StallCount    = stall_cnt;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between the decode stage (register file plus main controller) and the execute stage, with integrated load-use hazard detection. Each cycle it captures the controller's control word and the decoded operands. When a load in EX feeds the instruction in ID, it inserts a one-cycle bubble and freezes PC and IF/ID. It also applies the branch/jump flush and keeps a saturating stall-cycle counter for lab performance reporting.

## Interface
- No parameters; all widths fixed.
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous reset, active-low
- RegWrite_in, ALUSrc_in, MemWrite_in, MemRead_in, MemToReg_in, Branch_in, Jump_in, LoadType_in, StoreType_in  in  1 each  controller outputs for instruction in ID
- ALUOp_in  in  4  controller ALU operation
- RegDst_in  in  3  controller destination select
- ReadData1_in, ReadData2_in  in  32 each  register file outputs
- SignExt_in  in  32  sign-extended immediate
- PCPlus4_in  in  32  PC+4 of instruction in ID
- Rs_in, Rt_in, Rd_in, Shamt_in  in  5 each  instruction fields
- Flush  in  1  redirect from branch/jump resolution; kills instruction in ID
- *_out  out  same widths  registered copy of every *_in above
- Valid_out  out  1  1 = EX holds a real instruction, 0 = bubble
- Stall  out  1  load-use hazard detected this cycle (combinational)
- PCWrite  out  1  ~Stall; PC register enable
- IFIDWrite  out  1  ~Stall; IF/ID register enable
- StallCount  out  16  saturating count of stall cycles

## Operation
- Hazard detect: Stall = MemRead_out & Valid_out & (Rt_out != 0) & ((Rt_out == Rs_in) | (Rt_out == Rt_in)) & ~Flush. The Rt compare is unconditional. Over-stalling on instructions that do not read Rt is accepted.
- Per-edge update, priority order:
  1. Flush = 1: load bubble.
  2. Stall = 1: load bubble.
  3. Otherwise: capture all *_in, Valid_out <= 1.
- Bubble definition:
  - All control outputs 0: RegWrite, MemWrite, MemRead, Branch, Jump, LoadType, StoreType, ALUSrc, MemToReg, ALUOp = 0, RegDst = 0.
  - Valid_out <= 0.
  - Data fields (ReadData*, SignExt, PCPlus4, Rs/Rt/Rd/Shamt) still capture *_in so that waveforms stay readable. Consumers must not act on them when Valid_out = 0.
- Stall self-clears: after a bubble, MemRead_out = 0, so at most one stall cycle per load.
- StallCount increments by 1 on each edge where Stall = 1. It holds at 16'hFFFF and does not wrap. Flush cycles are not counted.
- Flush with a hazard present: Stall is forced 0, so PC/IF/ID are free to take the redirect. The bubble still loads.

## Timing
- Latency: *_in sampled at edge N appear on *_out after edge N. One-cycle register.
- Stall, PCWrite, IFIDWrite are combinational from registered EX state plus current Rs_in/Rt_in/Flush. They are valid the same cycle, before the next edge.
- Reset (Rst = 0, asynchronous): all *_out = 0, Valid_out = 0, StallCount = 0. Stall = 0, PCWrite = 1, IFIDWrite = 1 while in reset and immediately after.
- Reset asserted mid-stall: outputs clear at once. The next instruction proceeds with no residual stall.
- Rst release is synchronized externally; capture resumes on the first rising edge with Rst = 1.

## Test plan
- Reset: hold Rst = 0 with random inputs over 3 edges -> all outputs 0, PCWrite = IFIDWrite = 1, StallCount = 0. Release -> next edge captures RegWrite_in = 1, ALUOp_in = 4'h2, ReadData1_in = 32'hDEADBEEF unchanged.
- Load-use: edge 1 loads lw (MemRead_in = 1, Rt_in = 8). ID then holds Rs_in = 8. Expect:
  - Stall = 1, PCWrite = 0.
  - Edge 2 loads a bubble: Valid_out = 0, RegWrite_out = 0.
  - Stall = 0 after edge 2.
  - StallCount = 1.
- No false hazard:
  - lw with Rt = 0 followed by Rs_in = 0 -> Stall = 0.
  - lw with Rt = 9 followed by Rs = 10, Rt = 11 -> Stall = 0.
  - Non-load (MemRead_out = 0) with matching Rt -> Stall = 0.
- Flush: Flush = 1 with a valid add in ID (RegWrite_in = 1) -> after edge, Valid_out = 0, RegWrite_out = 0. Same with a concurrent hazard -> Stall = 0, PCWrite = 1, StallCount unchanged.
- Saturation: force 65 536 load-use pairs (or preload via reset-free long run) -> StallCount reaches 16'hFFFF and stays after further stalls.
- Async reset mid-stall: assert Rst = 0 between edges while Stall = 1 -> Stall drops to 0 and outputs clear without waiting for Clk.
